ram_io_responder: RTL and testbench

//  Target side of the byte-wide RAM bus (ram_rw/ram_addr/ram_w_data/ram_r_data) driven by the CPU memory controller.

---
 rtl/ram_io_responder_pkg.sv | 37 +++
 rtl/ram_io_responder_if.sv | 32 +++
 rtl/ram_io_responder_byte_fifo.sv | 71 +++++++
 rtl/ram_io_responder.sv | 132 +++++++++++++
 tb/tb_ram_io_responder.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/ram_io_responder_pkg.sv
// ============================================================================
// Module : ram_io_responder_pkg
// Brief  : Shared constants, access classification and address decode helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ram_io_responder_pkg;

  localparam logic [31:0] c_IO_BASE       = 32'h0003_0000;
  localparam logic [31:0] c_IO_OFS_DATA   = 32'd0;
  localparam logic [31:0] c_IO_OFS_STATUS = 32'd4;

  localparam int c_ST_TX_FULL = 0;
  localparam int c_ST_RX_NE   = 1;
  localparam int c_ST_TX_OVF  = 2;

  typedef enum logic [1:0] {
    ACC_RAM       = 2'd0,
    ACC_IO_DATA   = 2'd1,
    ACC_IO_STATUS = 2'd2,
    ACC_IO_OTHER  = 2'd3
  } access_e;

  function automatic access_e decode_access(input logic [31:0] addr,
                                            input logic [31:0] io_base);
    logic [31:0] ofs;
    ofs = addr - io_base;
    if (addr < io_base)             return ACC_RAM;
    else if (ofs == c_IO_OFS_DATA)   return ACC_IO_DATA;
    else if (ofs == c_IO_OFS_STATUS) return ACC_IO_STATUS;
    else                             return ACC_IO_OTHER;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_io_responder_if.sv
// ============================================================================
// Module : ram_io_responder_if
// Brief  : Byte RAM bus plus console TX/RX streams and halt flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ram_io_responder_if;
  logic        ram_rw;
  logic [31:0] ram_addr;
  logic [7:0]  ram_w_data;
  logic [7:0]  ram_r_data;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid;
  logic        io_tx_ready;
  logic [7:0]  io_rx_data;
  logic        io_rx_valid;
  logic        io_rx_ready;
  logic        io_halt;

  modport master (
    output ram_rw, ram_addr, ram_w_data, io_tx_ready, io_rx_data, io_rx_valid,
    input  ram_r_data, io_tx_data, io_tx_valid, io_rx_ready, io_halt
  );

  modport slave (
    input  ram_rw, ram_addr, ram_w_data, io_tx_ready, io_rx_data, io_rx_valid,
    output ram_r_data, io_tx_data, io_tx_valid, io_rx_ready, io_halt
  );
endinterface

`default_nettype wire

// File: rtl/ram_io_responder_byte_fifo.sv
// ============================================================================
// Module : ram_io_responder_byte_fifo
// Brief  : Byte FIFO with registered flags; push+pop together legal at any fill.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ram_io_responder_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_push,
  input  wire logic       i_pop,
  input  wire logic [7:0] i_din,
  output logic      [7:0] o_dout,
  output logic            o_full,
  output logic            o_empty
);

  localparam int                c_PTR_W    = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_FULL_CNT = (c_PTR_W + 1)'(DEPTH);

  logic [7:0]         r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               r_full;
  logic               r_empty;

  logic               w_do_push;
  logic               w_do_pop;
  logic [c_PTR_W:0]   w_count_nxt;

  // A pop frees the slot this cycle, so a push into a full FIFO still fits.
  assign w_do_pop  = i_pop && !r_empty;
  assign w_do_push = i_push && (!r_full || w_do_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop)      w_count_nxt = r_count + 1'b1;
    else if (w_do_pop && !w_do_push) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

`default_nettype wire

// File: rtl/ram_io_responder.sv
// ============================================================================
// Module : ram_io_responder
// Brief  : Byte RAM target with registered reads and an MMIO console window.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int          RAM_ADDR_BITS = 17,
  parameter logic [31:0] IO_BASE       = c_IO_BASE,
  parameter int          FIFO_DEPTH    = 16
) (
  input wire logic          clk,
  input wire logic          rst,
  ram_io_responder_if.slave bus
);

  localparam int c_RAM_SIZE = 1 << RAM_ADDR_BITS;

  logic [7:0]              r_mem [c_RAM_SIZE];
  logic [7:0]              r_ram_rdata;
  logic [7:0]              r_io_rdata;
  logic                    r_sel_ram;
  logic                    r_prev_rd_valid;
  logic [31:0]             r_prev_addr;
  logic                    r_tx_overflow;
  logic                    r_halt;

  access_e                 w_acc;
  logic [RAM_ADDR_BITS-1:0] w_idx;
  logic                    w_first_rd;
  logic                    w_tx_push;
  logic                    w_tx_pop;
  logic                    w_tx_drop;
  logic                    w_rx_push;
  logic                    w_rx_pop;
  logic [7:0]              w_tx_dout;
  logic [7:0]              w_rx_dout;
  logic                    w_tx_full;
  logic                    w_tx_empty;
  logic                    w_rx_full;
  logic                    w_rx_empty;
  logic [7:0]              w_status;
  logic [7:0]              w_io_rdata;

  assign w_acc = decode_access(bus.ram_addr, IO_BASE);
  assign w_idx = bus.ram_addr[RAM_ADDR_BITS-1:0];

  // A held read address pops the RX FIFO only once.
  assign w_first_rd = !r_prev_rd_valid || (r_prev_addr != bus.ram_addr);

  assign w_tx_push = bus.ram_rw && (w_acc == ACC_IO_DATA);
  assign w_tx_pop  = bus.io_tx_ready && !w_tx_empty;
  assign w_tx_drop = w_tx_push && w_tx_full && !w_tx_pop;
  assign w_rx_push = bus.io_rx_valid && !w_rx_full;
  assign w_rx_pop  = !bus.ram_rw && (w_acc == ACC_IO_DATA) && w_first_rd && !w_rx_empty;

  ram_io_responder_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_din   (bus.ram_w_data),
    .o_dout  (w_tx_dout),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  ram_io_responder_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_din   (bus.io_rx_data),
    .o_dout  (w_rx_dout),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  always_comb begin
    w_status               = 8'h00;
    w_status[c_ST_TX_FULL] = w_tx_full;
    w_status[c_ST_RX_NE]   = !w_rx_empty;
    w_status[c_ST_TX_OVF]  = r_tx_overflow;
  end

  always_comb begin
    w_io_rdata = 8'h00;
    case (w_acc)
      ACC_IO_DATA:   w_io_rdata = w_rx_dout;
      ACC_IO_STATUS: w_io_rdata = w_status;
      default:       w_io_rdata = 8'h00;
    endcase
  end

  // RAM kept free of reset so it maps onto block memory; the output mux carries reset.
  always_ff @(posedge clk) begin
    if (bus.ram_rw && (w_acc == ACC_RAM))  r_mem[w_idx] <= bus.ram_w_data;
    if (!bus.ram_rw && (w_acc == ACC_RAM)) r_ram_rdata  <= r_mem[w_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel_ram       <= 1'b0;
      r_io_rdata      <= 8'h00;
      r_prev_rd_valid <= 1'b0;
      r_prev_addr     <= 32'h0;
      r_tx_overflow   <= 1'b0;
      r_halt          <= 1'b0;
    end else begin
      r_prev_rd_valid <= !bus.ram_rw;
      r_prev_addr     <= bus.ram_addr;
      if (!bus.ram_rw) begin
        r_sel_ram  <= (w_acc == ACC_RAM);
        r_io_rdata <= w_io_rdata;
      end
      if (w_tx_drop) r_tx_overflow <= 1'b1;
      if (bus.ram_rw && (w_acc == ACC_IO_STATUS)) r_halt <= 1'b1;
    end
  end

  assign bus.ram_r_data  = r_sel_ram ? r_ram_rdata : r_io_rdata;
  assign bus.io_tx_data  = w_tx_dout;
  assign bus.io_tx_valid = !w_tx_empty;
  assign bus.io_rx_ready = !w_rx_full;
  assign bus.io_halt     = r_halt;

endmodule

`default_nettype wire

// File: tb/tb_ram_io_responder.sv
// ============================================================================
// Module : tb_ram_io_responder
// Brief  : Randomized bench against a queue-based model of the RAM/MMIO target.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ram_io_responder;

  localparam int          D    = 16;
  localparam int          AB   = 17;
  localparam logic [31:0] BASE = 32'h0003_0000;
  localparam int          N_CYC = 4000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_io_responder_if bus ();

  ram_io_responder #(
    .RAM_ADDR_BITS (AB),
    .IO_BASE       (BASE),
    .FIFO_DEPTH    (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic [7:0]  mem_m [int];
  logic [7:0]  txq [$];
  logic [7:0]  rxq [$];
  bit          ovf_m, halt_m, prev_rd_m;
  logic [31:0] prev_addr_m;
  logic [7:0]  exp_rd;
  bit          rd_known;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    ovf_m       = 0;
    halt_m      = 0;
    prev_rd_m   = 0;
    prev_addr_m = '0;
    exp_rd      = 8'h00;
    rd_known    = 1;
  endtask

  task automatic check_outputs();
    check_eq("tx_valid", bus.io_tx_valid, 32'(txq.size() > 0));
    check_eq("tx_data", bus.io_tx_data, (txq.size() > 0) ? 32'(txq[0]) : 32'h0);
    check_eq("rx_ready", bus.io_rx_ready, 32'(rxq.size() < D));
    check_eq("halt", bus.io_halt, 32'(halt_m));
    if (rd_known) check_eq("r_data", bus.ram_r_data, 32'(exp_rd));
  endtask

  task automatic model_step(input bit rw, input logic [31:0] addr, input logic [7:0] wd,
                            input bit txr, input bit rxv, input logic [7:0] rxd);
    bit tx_pop, tx_push, rx_push, rx_pop;
    int idx;
    logic [31:0] ofs;
    logic [7:0]  st;
    tx_pop  = (txq.size() > 0) && txr;
    rx_push = rxv && (rxq.size() < D);
    tx_push = 0;
    rx_pop  = 0;
    idx = int'(addr % (32'd1 << AB));
    ofs = addr - BASE;
    st  = {5'b0, ovf_m, rxq.size() > 0, txq.size() == D};
    if (rw) begin
      if (addr < BASE) mem_m[idx] = wd;
      else if (ofs == 0) begin
        if (txq.size() < D || tx_pop) tx_push = 1;
        else ovf_m = 1;
      end else if (ofs == 4) halt_m = 1;
    end else begin
      rd_known = 1;
      if (addr < BASE) begin
        if (mem_m.exists(idx)) exp_rd = mem_m[idx];
        else rd_known = 0;
      end else if (ofs == 0) begin
        exp_rd = (rxq.size() > 0) ? rxq[0] : 8'h00;
        if ((!prev_rd_m || prev_addr_m != addr) && rxq.size() > 0) rx_pop = 1;
      end else if (ofs == 4) exp_rd = st;
      else exp_rd = 8'h00;
    end
    if (tx_pop)  void'(txq.pop_front());
    if (tx_push) txq.push_back(wd);
    if (rx_pop)  void'(rxq.pop_front());
    if (rx_push) rxq.push_back(rxd);
    prev_rd_m   = !rw;
    prev_addr_m = addr;
  endtask

  initial begin
    bit          did_mid_rst;
    bit          rw;
    logic [31:0] addr;
    logic [7:0]  wd, rxd;
    bit          txr, rxv;
    int          phase, sel, wr_pct;
    did_mid_rst = 0;
    rst = 1'b1;
    bus.ram_rw      = 1'b0;
    bus.ram_addr    = '0;
    bus.ram_w_data  = '0;
    bus.io_tx_ready = 1'b0;
    bus.io_rx_data  = '0;
    bus.io_rx_valid = 1'b0;
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    addr = '0;
    rw   = 0;

    for (int it = 0; it < N_CYC; it++) begin
      check_outputs();

      if (!did_mid_rst && it >= N_CYC / 2 && txq.size() > 0) begin
        #2 rst = 1'b1;
        #1;
        check_eq("rst_tx_valid", bus.io_tx_valid, 0);
        check_eq("rst_tx_data", bus.io_tx_data, 0);
        check_eq("rst_halt", bus.io_halt, 0);
        check_eq("rst_r_data", bus.ram_r_data, 0);
        check_eq("rst_rx_ready", bus.io_rx_ready, 1);
        model_reset();
        #1 rst = 1'b0;
        did_mid_rst = 1;
      end

      phase  = (it / 200) % 4;
      wr_pct = (phase == 0 || phase == 3) ? 80 : 40;
      if ($urandom_range(0, 99) < 15 && !rw) begin
        rw = 0;  // hold the previous read address
      end else begin
        sel = int'($urandom_range(0, 9));
        case (sel)
          0, 1, 2: begin
            addr = 32'h100 + $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) addr = addr + 32'h2_0000;
            rw = 1'($urandom_range(0, 1));
          end
          3, 4, 5: begin
            addr = BASE;
            rw   = ($urandom_range(0, 99) < wr_pct);
          end
          6, 7: begin
            addr = BASE + 32'd4;
            rw   = ($urandom_range(0, 99) == 0);
          end
          8: begin
            addr = BASE + (($urandom_range(0, 1) == 1) ? 32'd8 : $urandom_range(1, 3));
            rw   = 1'($urandom_range(0, 1));
          end
          default: begin
            addr = 32'h8000_0000 | $urandom;
            rw   = 1'($urandom_range(0, 1));
          end
        endcase
      end
      wd  = 8'($urandom);
      rxd = 8'($urandom);
      txr = (phase == 0 || phase == 3) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 7);
      rxv = (phase == 2) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 3) == 0);

      bus.ram_rw      = rw;
      bus.ram_addr    = addr;
      bus.ram_w_data  = wd;
      bus.io_tx_ready = txr;
      bus.io_rx_valid = rxv;
      bus.io_rx_data  = rxd;
      model_step(rw, addr, wd, txr, rxv, rxd);
      @(negedge clk);
    end

    check_outputs();
    check_eq("mid_reset_exercised", did_mid_rst, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
